// File: rtl/dcache_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_write_buffer_pkg
//  Brief    : Shared bus definitions for the data-cache posted-write buffer:
//             bus widths, the buffered store entry and the bus operation
//             decode.
//  Revision : 1.0  initial release
// ============================================================================
package dcache_write_buffer_pkg;

    // Address and data widths on both the cache side and the system bus side.
    localparam int unsigned C_BUS_AW = 32;
    localparam int unsigned C_BUS_DW = 32;

    // One buffered store. The address sits in the upper half so a raw
    // {addr, data} concatenation and this struct line up bit for bit.
    typedef struct packed {
        logic [C_BUS_AW-1:0] addr;
        logic [C_BUS_DW-1:0] data;
    } wb_entry_t;

    localparam int unsigned C_ENTRY_W = $bits(wb_entry_t);

    // What the cache is asking for in the current cycle.
    typedef enum logic [1:0] {
        BUS_IDLE = 2'b00,
        BUS_RD   = 2'b01,
        BUS_WR   = 2'b10
    } bus_op_e;

    // The cache issues one request at a time. If both strobes were ever
    // raised together, the write wins so that a store is never lost.
    function automatic bus_op_e decode_op(input logic req,
                                          input logic rd,
                                          input logic wr);
        bus_op_e op;
        op = BUS_IDLE;
        if (req) begin
            if (wr) begin
                op = BUS_WR;
            end else if (rd) begin
                op = BUS_RD;
            end
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_write_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock circular FIFO with wrap-bit pointers. Exposes the
//             head entry combinationally; push and pop may occur together.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    // Pointers carry one extra wrap bit above the AW index bits, which
    // separates "full" from "empty" when the index bits are equal.
    logic [AW:0]      r_wr_ptr_q;
    logic [AW:0]      r_rd_ptr_q;
    logic [AW:0]      w_wr_ptr_d;
    logic [AW:0]      w_rd_ptr_d;
    logic             w_do_push;
    logic             w_do_pop;
    logic [WIDTH-1:0] r_mem_q [DEPTH];

    // Status flags decoded from the registered pointers only.
    always_comb begin
        empty = (r_wr_ptr_q == r_rd_ptr_q);
        full  = (r_wr_ptr_q[AW-1:0] == r_rd_ptr_q[AW-1:0]) &&
                (r_wr_ptr_q[AW]     != r_rd_ptr_q[AW]);
        head  = r_mem_q[r_rd_ptr_q[AW-1:0]];
    end

    // Next-pointer computation; requests that would overflow or underflow
    // are ignored so the pointers can never cross.
    always_comb begin
        w_do_push  = push && !full;
        w_do_pop   = pop && !empty;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        if (w_do_push) begin
            w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        end
        if (w_do_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; reset discards every buffered entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
        end
    end

    // Storage array; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem_q[r_wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dcache_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_write_buffer
//  Brief    : Posted-write buffer between the data cache bus master port and
//             the system bus arbiter. Stores are absorbed in one cycle and
//             drained in order; reads pass through only once the buffer is
//             empty, so a read never overtakes an older store.
//  Revision : 1.0  initial release
// ============================================================================
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    // cache side
    input  logic                c_bus_req,
    output logic                c_bus_ack,
    input  logic [C_BUS_AW-1:0] c_bus_addr,
    input  logic                c_bus_rd,
    input  logic                c_bus_wr,
    input  logic [C_BUS_DW-1:0] c_bus_wdata,
    output logic [C_BUS_DW-1:0] c_bus_rdata,
    output logic                c_bus_ready,
    // system bus side
    output logic                m_bus_req,
    input  logic                m_bus_ack,
    output logic [C_BUS_AW-1:0] m_bus_addr,
    output logic                m_bus_rd,
    output logic                m_bus_wr,
    output logic [C_BUS_DW-1:0] m_bus_wdata,
    input  logic [C_BUS_DW-1:0] m_bus_rdata,
    input  logic                m_bus_ready,
    // status
    output logic                wb_empty
);

    bus_op_e   w_op;
    wb_entry_t w_push_entry;
    wb_entry_t w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_wr_accept;
    logic      w_rd_pass;
    logic      w_drain;
    logic      w_pop;

    // Store storage and pointer management.
    sync_fifo #(
        .WIDTH (C_ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_accept),
        .din   (w_push_entry),
        .pop   (w_pop),
        .head  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    // Classify the cache request and decide which path owns the bus.
    always_comb begin
        w_op         = decode_op(c_bus_req, c_bus_rd, c_bus_wr);
        w_push_entry = '{addr: c_bus_addr, data: c_bus_wdata};
        w_wr_accept  = 1'b0;
        w_rd_pass    = 1'b0;
        w_drain      = 1'b0;
        w_pop        = 1'b0;
        if (!rst) begin
            // Full is judged on registered pointers: a pop this cycle does
            // not free a slot until the next one.
            w_wr_accept = (w_op == BUS_WR) && !w_full;
            // Reads wait until every older store has left the buffer.
            w_rd_pass   = (w_op == BUS_RD) && w_empty;
            w_drain     = !w_empty;
            w_pop       = w_drain && m_bus_ack && m_bus_ready;
        end
    end

    // Output steering: stores are answered locally, reads mirror the bus,
    // and the head entry drives the bus while the buffer is non-empty.
    always_comb begin
        c_bus_ack   = 1'b0;
        c_bus_ready = 1'b0;
        c_bus_rdata = '0;
        m_bus_req   = 1'b0;
        m_bus_rd    = 1'b0;
        m_bus_wr    = 1'b0;
        m_bus_addr  = '0;
        m_bus_wdata = '0;
        if (w_wr_accept) begin
            c_bus_ack   = 1'b1;
            c_bus_ready = 1'b1;
        end
        if (w_drain) begin
            m_bus_req = 1'b1;
            if (m_bus_ack) begin
                m_bus_wr    = 1'b1;
                m_bus_addr  = w_head.addr;
                m_bus_wdata = w_head.data;
            end
        end else if (w_rd_pass) begin
            m_bus_req   = 1'b1;
            c_bus_ack   = m_bus_ack;
            c_bus_ready = m_bus_ready;
            c_bus_rdata = m_bus_rdata;
            if (m_bus_ack) begin
                m_bus_rd   = 1'b1;
                m_bus_addr = c_bus_addr;
            end
        end
    end

    // Fence/DMA status; held high throughout reset.
    always_comb begin
        wb_empty = w_empty || rst;
    end

endmodule
`default_nettype wire
